// File: rtl/clk_prescaller_pkg.sv
// Shared definitions for the system clock prescaler and its tick consumers.
package clk_prescaller_pkg;

    // Default width of the prescaler tap bus.
    localparam int unsigned DIV_RESOLUTION_DEF = 4;

    // Tick generator control states.
    typedef enum logic [1:0] {
        StOff,
        StRun,
        StPend
    } pclk_tick_state_t;

    // Selector width able to encode bypass (0) plus every tap (1..div_res).
    function automatic int unsigned sel_width(input int unsigned div_res);
        return $clog2(div_res + 1);
    endfunction

endpackage

// File: rtl/pclk_edge_det.sv
// Tap history register and rising-edge detection on the selected prescaler tap.
module pclk_edge_det
    import clk_prescaller_pkg::*;
#(
    parameter int unsigned  DIV_RESOLUTION = DIV_RESOLUTION_DEF,
    localparam int unsigned SEL_W          = sel_width(DIV_RESOLUTION)
) (
    input  logic                      in_clk,
    input  logic                      sys_rst_n,
    input  logic [DIV_RESOLUTION-1:0] pclk_in,
    input  logic [SEL_W-1:0]          sel,
    output logic                      base_edge
);

    logic [DIV_RESOLUTION-1:0] tap_q;

    // Remember last cycle's tap levels for edge detection.
    always_ff @(posedge in_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tap_q <= '0;
        end else begin
            tap_q <= pclk_in;
        end
    end

    // Bypass gives an edge every cycle; otherwise a 0->1 on tap sel-1.
    always_comb begin
        base_edge = (sel == '0);
        for (int i = 0; i < int'(DIV_RESOLUTION); i++) begin
            if (sel == SEL_W'(i + 1)) begin
                base_edge = pclk_in[i] & ~tap_q[i];
            end
        end
    end

endmodule

// File: rtl/pclk_tick_gen.sv
// Selects a prescaler tap, postscales its edges and emits a one-cycle tick.
// Reconfiguration while running is deferred to the next tick boundary.
module pclk_tick_gen
    import clk_prescaller_pkg::*;
#(
    parameter int unsigned  DIV_RESOLUTION = DIV_RESOLUTION_DEF,
    parameter int unsigned  POST_W         = 8,
    localparam int unsigned SEL_W          = sel_width(DIV_RESOLUTION)
) (
    input  logic                      in_clk,
    input  logic                      sys_rst_n,
    input  logic [DIV_RESOLUTION-1:0] pclk_in,
    input  logic                      en,
    input  logic                      cfg_wr,
    input  logic [SEL_W-1:0]          cfg_sel,
    input  logic [POST_W-1:0]         cfg_post,
    output logic                      tick_out,
    output logic [SEL_W-1:0]          cur_sel,
    output logic [POST_W-1:0]         cur_post,
    output logic                      busy
);

    pclk_tick_state_t  state_q, state_d;
    logic [POST_W-1:0] post_cnt_q, post_cnt_d;
    logic [POST_W-1:0] cur_post_q, cur_post_d;
    logic [POST_W-1:0] pend_post_q, pend_post_d;
    logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]  pend_sel_q, pend_sel_d;
    logic [SEL_W-1:0]  sel_wr;
    logic              busy_q, busy_d;
    logic              tick_q, tick_d;
    logic              base_edge;
    logic              terminal;

    pclk_edge_det #(
        .DIV_RESOLUTION (DIV_RESOLUTION)
    ) u_edge_det (
        .in_clk    (in_clk),
        .sys_rst_n (sys_rst_n),
        .pclk_in   (pclk_in),
        .sel       (cur_sel_q),
        .base_edge (base_edge)
    );

    // Out-of-range selectors saturate to the slowest tap.
    always_comb begin
        sel_wr = cfg_sel;
        if (32'(cfg_sel) > DIV_RESOLUTION) begin
            sel_wr = SEL_W'(DIV_RESOLUTION);
        end
    end

    assign terminal = base_edge && (post_cnt_q == cur_post_q);

    // Next-state: postscale counting, deferred config swap and enable handling.
    always_comb begin
        state_d     = state_q;
        post_cnt_d  = post_cnt_q;
        cur_sel_d   = cur_sel_q;
        cur_post_d  = cur_post_q;
        pend_sel_d  = pend_sel_q;
        pend_post_d = pend_post_q;
        busy_d      = busy_q;
        tick_d      = 1'b0;

        unique case (state_q)
            StOff: begin
                if (cfg_wr) begin
                    cur_sel_d  = sel_wr;
                    cur_post_d = cfg_post;
                end
                if (en) begin
                    state_d    = StRun;
                    post_cnt_d = '0;
                end
            end
            StRun, StPend: begin
                if (base_edge) begin
                    if (terminal) begin
                        tick_d     = 1'b1;
                        post_cnt_d = '0;
                    end else begin
                        post_cnt_d = post_cnt_q + POST_W'(1);
                    end
                end
                // The tick that closes the old period is where the new config lands.
                if (state_q == StPend && terminal) begin
                    cur_sel_d  = pend_sel_q;
                    cur_post_d = pend_post_q;
                    busy_d     = 1'b0;
                    state_d    = StRun;
                end
                if (cfg_wr) begin
                    pend_sel_d  = sel_wr;
                    pend_post_d = cfg_post;
                    busy_d      = 1'b1;
                    state_d     = StPend;
                end
                // Stopping flushes any pending config straight into the active set.
                if (!en) begin
                    state_d    = StOff;
                    post_cnt_d = '0;
                    busy_d     = 1'b0;
                    if (cfg_wr) begin
                        cur_sel_d  = sel_wr;
                        cur_post_d = cfg_post;
                    end else if (state_q == StPend) begin
                        cur_sel_d  = pend_sel_q;
                        cur_post_d = pend_post_q;
                    end
                end
            end
            default: begin
                state_d = StOff;
            end
        endcase
    end

    // State and configuration registers.
    always_ff @(posedge in_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StOff;
            post_cnt_q  <= '0;
            cur_sel_q   <= '0;
            cur_post_q  <= '0;
            pend_sel_q  <= '0;
            pend_post_q <= '0;
            busy_q      <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            post_cnt_q  <= post_cnt_d;
            cur_sel_q   <= cur_sel_d;
            cur_post_q  <= cur_post_d;
            pend_sel_q  <= pend_sel_d;
            pend_post_q <= pend_post_d;
            busy_q      <= busy_d;
            tick_q      <= tick_d;
        end
    end

    assign tick_out = tick_q;
    assign cur_sel  = cur_sel_q;
    assign cur_post = cur_post_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_pclk_tick_gen.sv
// Bench for pclk_tick_gen: expected tick cycles go into a queue as stimulus is
// applied and are matched against observed ticks.
module tb_pclk_tick_gen;

    typedef struct {
        int sel;
        int post;
        int exp_sel;
        int exp_per;
    } vec_t;

    logic       in_clk = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic [3:0] pclk_in;
    logic       en = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [2:0] cfg_sel = '0;
    logic [7:0] cfg_post = '0;
    logic       tick_out;
    logic [2:0] cur_sel;
    logic [7:0] cur_post;
    logic       busy;

    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;
    int  exp_q[$];
    bit  mon_on = 1'b0;
    int  tick_seen = 0;

    pclk_tick_gen dut (
        .in_clk    (in_clk),
        .sys_rst_n (sys_rst_n),
        .pclk_in   (pclk_in),
        .en        (en),
        .cfg_wr    (cfg_wr),
        .cfg_sel   (cfg_sel),
        .cfg_post  (cfg_post),
        .tick_out  (tick_out),
        .cur_sel   (cur_sel),
        .cur_post  (cur_post),
        .busy      (busy)
    );

    always #5 in_clk = ~in_clk;

    // Prescaler model: free-running counter released together with the DUT.
    always @(posedge in_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end
    assign pclk_in = cyc[3:0];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and score any tick seen there.
    task automatic step();
        int e;
        @(negedge in_clk);
        if (mon_on && tick_out) begin
            tick_seen++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL tick_unexpected: tick at cycle %0d, none expected", cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e) begin
                    n_err++;
                    $display("FAIL tick_time: tick at cycle %0d expected cycle %0d", cyc, e);
                end
            end
        end
    endtask

    task automatic write_cfg(input int s, input int p);
        cfg_wr   = 1'b1;
        cfg_sel  = 3'(s);
        cfg_post = 8'(p);
        step();
        cfg_wr   = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Ticks land one cycle after the (p+1)th selected edge seen from cycle t on.
    function automatic int first_gap(input int t, input int s, input int p);
        int n = 0;
        for (int c = t; c < t + 5000; c++) begin
            if (s == 0 || (c % (1 << s)) == (1 << (s - 1))) begin
                n++;
                if (n == p + 1) return c + 1 - t;
            end
        end
        return -1;
    endfunction

    // Stop, program in OFF, restart and queue the first n ticks.
    task automatic start_run(input int s, input int p, input int s_exp, input int per,
                             input int n);
        int e;
        int f;
        mon_on = 1'b0;
        en     = 1'b0;
        repeat (3) step();
        exp_q.delete();
        mon_on = 1'b1;
        write_cfg(s, p);
        chk("off_cur_sel", int'(cur_sel), s_exp);
        chk("off_cur_post", int'(cur_post), p);
        chk("off_busy", int'(busy), 0);
        en = 1'b1;
        e  = cyc + 1;
        f  = e + first_gap(e, s_exp, p);
        for (int k = 0; k < n; k++) exp_q.push_back(f + k * per);
    endtask

    initial begin
        vec_t vecs[6];
        int   c0;
        int   t;
        int   f;

        vecs[0] = '{sel: 0, post: 0, exp_sel: 0, exp_per: 1};
        vecs[1] = '{sel: 0, post: 3, exp_sel: 0, exp_per: 4};
        vecs[2] = '{sel: 2, post: 0, exp_sel: 2, exp_per: 4};
        vecs[3] = '{sel: 2, post: 2, exp_sel: 2, exp_per: 12};
        vecs[4] = '{sel: 7, post: 0, exp_sel: 4, exp_per: 16};
        vecs[5] = '{sel: 1, post: 5, exp_sel: 1, exp_per: 12};

        #1 sys_rst_n = 1'b0;
        @(negedge in_clk);
        @(negedge in_clk);
        chk("rst_tick", int'(tick_out), 0);
        chk("rst_cur_sel", int'(cur_sel), 0);
        chk("rst_cur_post", int'(cur_post), 0);
        chk("rst_busy", int'(busy), 0);
        sys_rst_n = 1'b1;

        // Steady-state periods for a spread of selector/postscale settings.
        for (int i = 0; i < 6; i++) begin
            start_run(vecs[i].sel, vecs[i].post, vecs[i].exp_sel, vecs[i].exp_per, 3);
            wait_drain($sformatf("vec%0d_ticks", i), 4 * vecs[i].exp_per + 40);
        end

        // Bypass, postscale change on a terminal edge: old tick, then switch.
        start_run(0, 0, 0, 1, 4);
        wait_drain("byp_start", 40);
        c0 = cyc;
        exp_q.push_back(c0 + 1);
        exp_q.push_back(c0 + 2);
        write_cfg(0, 3);
        chk("byp_busy_set", int'(busy), 1);
        chk("byp_post_old", int'(cur_post), 0);
        step();
        chk("byp_busy_clr", int'(busy), 0);
        chk("byp_post_new", int'(cur_post), 3);
        t = c0 + 2;
        f = t + first_gap(t, 0, 3);
        for (int k = 0; k < 3; k++) exp_q.push_back(f + 4 * k);
        wait_drain("byp_post_ticks", 60);

        // Selector change mid-period: busy until the old tick, then period 8.
        start_run(1, 0, 1, 2, 2);
        wait_drain("sel1_start", 40);
        c0 = cyc;
        exp_q.push_back(c0 + 2);
        write_cfg(3, 0);
        chk("sel_busy_set", int'(busy), 1);
        chk("sel_cur_old", int'(cur_sel), 1);
        step();
        chk("sel_busy_clr", int'(busy), 0);
        chk("sel_cur_new", int'(cur_sel), 3);
        t = c0 + 2;
        f = t + first_gap(t, 3, 0);
        for (int k = 0; k < 3; k++) exp_q.push_back(f + 8 * k);
        wait_drain("sel3_ticks", 60);

        // Two writes in PEND, the last one (clamped) wins.
        c0 = cyc;
        exp_q.push_back(c0 + 8);
        write_cfg(1, 9);
        write_cfg(7, 0);
        chk("pend2_busy", int'(busy), 1);
        chk("pend2_cur_sel", int'(cur_sel), 3);
        t = c0 + 8;
        f = t + first_gap(t, 4, 0);
        exp_q.push_back(f);
        exp_q.push_back(f + 16);
        wait_drain("pend2_ticks", 80);
        chk("pend2_sel_clamp", int'(cur_sel), 4);
        chk("pend2_post", int'(cur_post), 0);
        chk("pend2_busy_clr", int'(busy), 0);

        // Disable with a write pending: applied at once, no more ticks.
        write_cfg(2, 3);
        chk("dis_busy_set", int'(busy), 1);
        en = 1'b0;
        step();
        chk("dis_busy", int'(busy), 0);
        chk("dis_cur_sel", int'(cur_sel), 2);
        chk("dis_cur_post", int'(cur_post), 3);
        tick_seen = 0;
        repeat (40) step();
        chk("dis_no_ticks", tick_seen, 0);
        write_cfg(1, 1);
        chk("dis_off_busy", int'(busy), 0);
        chk("dis_off_sel", int'(cur_sel), 1);

        // Asynchronous reset while a tick is out and a write is pending.
        mon_on = 1'b0;
        write_cfg(0, 0);
        en = 1'b1;
        repeat (3) step();
        write_cfg(3, 5);
        chk("arst_pre_tick", int'(tick_out), 1);
        chk("arst_pre_busy", int'(busy), 1);
        sys_rst_n = 1'b0;
        #1;
        chk("arst_tick", int'(tick_out), 0);
        chk("arst_cur_sel", int'(cur_sel), 0);
        chk("arst_cur_post", int'(cur_post), 0);
        chk("arst_busy", int'(busy), 0);
        en = 1'b0;
        @(negedge in_clk);
        @(negedge in_clk);
        sys_rst_n = 1'b1;
        repeat (4) step();
        chk("arst_after_sel", int'(cur_sel), 0);
        chk("arst_after_busy", int'(busy), 0);
        chk("arst_after_tick", int'(tick_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pclk_tick_gen.md
# pclk_tick_gen

Consumer side of the system clock prescaler. Takes the prescaler's free-running divided-clock bus and selects one tap, or bypass, through a programmable selector. It applies a programmable postscaler and emits a single-cycle, glitch-free tick enable in the `in_clk` domain for downstream peripherals. Selector and postscaler changes made while running take effect only at a tick boundary, so no period is ever truncated.

## Interface
- `DIV_RESOLUTION`, default 4: width of the prescaler tap bus; selectable divide is 2^0 .. 2^DIV_RESOLUTION.
- `POST_W`, default 8: postscaler width; tick period multiplier is 1 .. 2^POST_W.
- `SEL_W` (localparam) = $clog2(DIV_RESOLUTION+1): 3 at default.

Ports:
- `in_clk`  in  1  block clock; same clock that drives the prescaler.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `pclk_in`  in  DIV_RESOLUTION  prescaler tap bus, synchronous to `in_clk`.
- `en`  in  1  run enable.
- `cfg_wr`  in  1  one-cycle write strobe for `cfg_sel`/`cfg_post`.
- `cfg_sel`  in  SEL_W  0 = bypass (base edge every cycle); k = rising edge of `pclk_in[k-1]`.
- `cfg_post`  in  POST_W  ticks are emitted every (`cfg_post`+1) base edges.
- `tick_out`  out  1  registered one-cycle tick.
- `cur_sel`  out  SEL_W  active selector.
- `cur_post`  out  POST_W  active postscale.
- `busy`  out  1  a written configuration is pending.

## Operation
- Tap history: `tap_q` <= `pclk_in` every cycle.
- Base edge: `base_edge` = 1 when `cur_sel`=0. Otherwise `base_edge` = `pclk_in[cur_sel-1]` & ~`tap_q[cur_sel-1]`. Base period is 2^`cur_sel` cycles.
- `cfg_sel` > DIV_RESOLUTION is clamped to DIV_RESOLUTION on write.
- FSM states: OFF, RUN, PEND.
- OFF:
  - `cfg_wr` loads `cur_sel`/`cur_post` directly; `busy` stays 0.
  - `en`=1 -> RUN with `post_cnt`=0.
- RUN:
  - Each `base_edge` increments `post_cnt`.
  - On `base_edge` with `post_cnt`==`cur_post`: `tick_out` fires next cycle and `post_cnt` returns to 0.
  - `cfg_wr` stores to `pend_sel`/`pend_post`, sets `busy`, -> PEND.
- PEND:
  - Counting continues with the old configuration.
  - A further `cfg_wr` overwrites the pending values; last write wins.
  - On the terminal base edge, the tick fires with the old configuration. The same cycle loads `pend_*` into `cur_*`, clears `post_cnt` and `busy`, and -> RUN.
- `cfg_wr` in the same cycle as a RUN terminal edge: that tick uses the old configuration. The write goes to PEND and is applied at the following tick.
- `en`=0 in RUN or PEND:
  - -> OFF next cycle and `post_cnt` cleared.
  - Any pending configuration is applied immediately and `busy` cleared.
  - A tick already decided in that cycle is still emitted.
- Width rules: `post_cnt` is POST_W bits and never wraps, because it clears on reaching `cur_post`. `cur_post`=2^POST_W-1 gives the maximum period.

## Timing
- Reset values: `tick_out`=0, `cur_sel`=0, `cur_post`=0, `busy`=0, `tap_q`=0, `post_cnt`=0, state OFF.
- `tick_out` is registered: asserted exactly 1 cycle after the qualifying `base_edge` cycle, high for exactly 1 cycle.
- Steady-state tick period is 2^`cur_sel` × (`cur_post`+1) cycles.
- After a reconfiguration, the first new period is measured from the switching tick. The first tick falls on the first new-tap rising edge that completes `cur_post`+1 edges after that point.
- `cur_sel`/`cur_post`/`busy` update 1 cycle after the event that changes them.
- First tick after `en` rises: counting starts the cycle the FSM is in RUN. Base edges in the OFF cycle are not counted.
- Reset asserted mid-operation: all state returns to reset values asynchronously, and the pending configuration is discarded.

## Structure
- Shared package `clk_prescaller_pkg` holds:
  - the FSM enum `pclk_tick_state_t` (OFF/RUN/PEND);
  - the default DIV_RESOLUTION constant;
  - the `SEL_W` computation function.
- One sub-module, `pclk_edge_det`: it owns `tap_q` and the tap-mux rising-edge detection, and outputs `base_edge`. The FSM, postscaler and config registers stay in the top.

## Test plan
All scenarios drive `pclk_in` from the prescaler, released from reset together, so `pclk_in` = cycle count mod 16.
- Reset asserted while `tick_out` is active -> all outputs 0 asynchronously; `cur_sel`=0, `busy`=0.
- `cfg_sel`=0, `cfg_post`=0, `en`=1 -> `tick_out` high every cycle. Then `cfg_post`=3 -> exactly one tick every 4 cycles.
- `cfg_sel`=2, `cfg_post`=0 -> ticks 4 cycles apart. Then `cfg_sel`=2, `cfg_post`=2 written in OFF -> ticks 12 cycles apart.
- Running with `cfg_sel`=1; write `cfg_sel`=3 mid-period -> `busy`=1 until the next old-period tick (2 cycles after the previous one), then ticks 8 cycles apart. No interval is shorter than 2 cycles, and `busy` clears on the switch.
- `cfg_sel`=7 written -> `cur_sel` reads 4, ticks 16 cycles apart. Two `cfg_wr` while in PEND -> only the last write is applied.
- `en` dropped with a pending write -> state OFF, `busy`=0, `cur_*` equal the pending values, and no further ticks.
